// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared pipeline stage-register types and default widths
package pipe_stage_reg_pkg;

    localparam int PIPE_DATA_W = 16;
    localparam int PIPE_ADDR_W = 16;
    localparam int PIPE_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // A stage can take a new entry unless both main and skid registers are occupied.
    function automatic logic stage_has_room(stage_state_e s);
        return (s != ST_TWO);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid pipeline register with flush and stall counter
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int ADDR_W = PIPE_ADDR_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_instr,
    input  logic              in_hit,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_instr,
    output logic              out_hit,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] main_addr_q, main_addr_d;
    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic              main_hit_q, main_hit_d;
    logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic              skid_hit_q, skid_hit_d;
    logic              in_fire;
    logic              out_fire;
    logic              stall_inc;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;
    assign stall_inc = out_valid & ~out_ready & ~flush;

    always_comb begin
        state_d      = state_q;
        main_addr_d  = main_addr_q;
        main_instr_d = main_instr_q;
        main_hit_d   = main_hit_q;
        skid_addr_d  = skid_addr_q;
        skid_instr_d = skid_instr_q;
        skid_hit_d   = skid_hit_q;

        // Flush only drops occupancy; payload registers keep their last contents.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        main_addr_d  = in_addr;
                        main_instr_d = in_instr;
                        main_hit_d   = in_hit;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_addr_d  = in_addr;
                        main_instr_d = in_instr;
                        main_hit_d   = in_hit;
                    end else if (in_fire) begin
                        state_d      = ST_TWO;
                        skid_addr_d  = in_addr;
                        skid_instr_d = in_instr;
                        skid_hit_d   = in_hit;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d      = ST_ONE;
                        main_addr_d  = skid_addr_q;
                        main_instr_d = skid_instr_q;
                        main_hit_d   = skid_hit_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d = stage_has_room(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            main_addr_q  <= '0;
            main_instr_q <= '0;
            main_hit_q   <= 1'b0;
            skid_addr_q  <= '0;
            skid_instr_q <= '0;
            skid_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            main_addr_q  <= main_addr_d;
            main_instr_q <= main_instr_d;
            main_hit_q   <= main_hit_d;
            skid_addr_q  <= skid_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_hit_q   <= skid_hit_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_addr  = main_addr_q;
    assign out_instr = main_instr_q;
    assign out_hit   = main_hit_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .count(stall_cnt)
    );

endmodule
